// File: rtl/aukv_uart_rx_fifo.sv
// aukv_uart_rx_fifo: parametrised UART receiver with a first-word fall-through output FIFO.
// The serial line is synchronised, deserialised LSB first, optionally parity-checked and
// stop-bit-checked, then pushed into a small FIFO read through a valid/ready handshake.
// Three sticky error flags report parity failures, framing failures and FIFO overruns.
module aukv_uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rx,
    output logic [DATA_BITS-1:0]          o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    input  logic                          i_clr_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = 4;

    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [PTR_W:0]   FULL_LVL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic             ODD_MODE  = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q;
    logic                   rxMeta_q, rxSync_q, rxPrev_q;
    logic [CNT_W-1:0]       bitCnt_q;
    logic [IDX_W-1:0]       bitIdx_q;
    logic                   stopIdx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   parFail_q, stopBad_q, busy_q;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr_q, rdPtr_q;
    logic [PTR_W:0]         count_q, count_d;
    logic                   parityErr_q, frameErr_q, overrun_q;

    logic sampleTick, lastStop, stopOk, pushReq, popReq, fifoFull, pushAccept;
    logic frameErrEv, parityErrEv, overrunEv;

    assign sampleTick  = (bitCnt_q == LAST_CNT);
    assign lastStop    = (state_q == ST_STOP) && sampleTick && (stopIdx_q == LAST_STOP);
    assign stopOk      = rxSync_q && !stopBad_q;
    assign pushReq     = lastStop && stopOk;
    assign frameErrEv  = lastStop && !stopOk;
    assign parityErrEv = pushReq && parFail_q;

    assign fifoFull    = (count_q == FULL_LVL);
    assign popReq      = (count_q != '0) && i_ready;
    assign pushAccept  = pushReq && (!fifoFull || popReq);
    assign overrunEv   = pushReq && fifoFull && !popReq;

    assign o_valid      = (count_q != '0);
    assign o_level      = count_q;
    assign o_data       = o_valid ? mem_q[rdPtr_q] : '0;
    assign o_busy       = busy_q;
    assign o_parity_err = parityErr_q;
    assign o_frame_err  = frameErr_q;
    assign o_overrun    = overrun_q;

    // Two-flop synchroniser plus one history flop so a falling edge on the line can be seen.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= i_rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // Frame FSM: start validation at half a bit, then one sample per bit period at mid-bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            bitCnt_q  <= '0;
            bitIdx_q  <= '0;
            stopIdx_q <= 1'b0;
            shift_q   <= '0;
            parFail_q <= 1'b0;
            stopBad_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bitCnt_q <= '0;
                    if (rxPrev_q && !rxSync_q) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bitCnt_q == HALF_CNT) begin
                        bitCnt_q <= '0;
                        if (rxSync_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q  <= ST_DATA;
                            bitIdx_q <= '0;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sampleTick) begin
                        bitCnt_q <= '0;
                        shift_q  <= {rxSync_q, shift_q[DATA_BITS-1:1]};
                        bitIdx_q <= bitIdx_q + 1'b1;
                        if (bitIdx_q == LAST_DATA) begin
                            parFail_q <= 1'b0;
                            stopBad_q <= 1'b0;
                            stopIdx_q <= 1'b0;
                            state_q   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (sampleTick) begin
                        bitCnt_q  <= '0;
                        parFail_q <= ((^shift_q) ^ rxSync_q) != ODD_MODE;
                        state_q   <= ST_STOP;
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (sampleTick) begin
                        bitCnt_q <= '0;
                        if (!rxSync_q) begin
                            stopBad_q <= 1'b1;
                        end
                        if (stopIdx_q == LAST_STOP) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            stopIdx_q <= stopIdx_q + 1'b1;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next occupancy: a push accepted alongside a pop leaves the level unchanged.
    always_comb begin
        count_d = count_q;
        case ({pushAccept, popReq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage is not reset; the head word is masked to zero while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (pushAccept) begin
            mem_q[wrPtr_q] <= shift_q;
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushAccept) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popReq) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Sticky error flags; a new error event takes priority over a clear request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (parityErrEv) begin
                parityErr_q <= 1'b1;
            end else if (i_clr_err) begin
                parityErr_q <= 1'b0;
            end
            if (frameErrEv) begin
                frameErr_q <= 1'b1;
            end else if (i_clr_err) begin
                frameErr_q <= 1'b0;
            end
            if (overrunEv) begin
                overrun_q <= 1'b1;
            end else if (i_clr_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

endmodule
